// File: rtl/ps2_led_sequencer_if.sv
// Signal bundle between the Set-LEDs sequencer (master side), the PS/2 controller
// and the keycode decoder (slave side).
interface ps2_led_sequencer_if;
  // Request side
  logic       led_req;
  logic [2:0] led_val;
  logic       busy;
  logic       done;
  logic       fail;
  logic [2:0] leds_applied;

  // PS/2 controller transmit/receive
  logic [7:0] the_command;
  logic       send_command;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic [7:0] received_data;
  logic       received_data_en;

  // Filtered stream towards the keycode decoder
  logic [7:0] rx_data;
  logic       rx_en;

  modport master (
    input  led_req, led_val,
    input  command_was_sent, error_communication_timed_out,
    input  received_data, received_data_en,
    output busy, done, fail, leds_applied,
    output the_command, send_command,
    output rx_data, rx_en
  );

  modport slave (
    output led_req, led_val,
    output command_was_sent, error_communication_timed_out,
    output received_data, received_data_en,
    input  busy, done, fail, leds_applied,
    input  the_command, send_command,
    input  rx_data, rx_en
  );
endinterface

// File: rtl/ps2_led_sequencer.sv
// Host-side PS/2 Set-LEDs sequencer (0xED + argument) with ACK/RESEND/timeout retries and
// ACK/RESEND removal from the receive stream. Optional macro LOCK_TRACK_EN: lock-key tracking.
module ps2_led_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 1000000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input logic                 CLOCK_50,
  input logic                 reset,
  ps2_led_sequencer_if.master bus
);

  localparam int unsigned TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [RTY_W:0]   RTY_LIMIT = (RTY_W + 1)'(MAX_RETRY);

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] KB_ACK       = 8'hFA;
  localparam logic [7:0] KB_RESEND    = 8'hFE;

  typedef enum logic [2:0] {
    IDLE,
    TX_CMD,
    WAIT_SENT1,
    WAIT_ACK1,
    TX_ARG,
    WAIT_SENT2,
    WAIT_ACK2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       arg_q, arg_d;
  logic             pend_q, pend_d;
  logic [2:0]       pend_val_q, pend_val_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [2:0]       leds_applied_q, leds_applied_d;
  logic [7:0]       the_command_q, the_command_d;
  logic             send_command_q, send_command_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_en_q, rx_en_d;

  logic             in_wait_ack;
  logic             second_byte;
  logic             ack_byte;
  logic             resend_byte;
  logic             rx_consumed;
  logic             rx_fwd;
  logic             req;
  logic [2:0]       req_val;
  logic             attempt_failed;
  logic [RTY_W:0]   retry_next;

  // ACK/RESEND are swallowed only while an acknowledge is actually awaited.
  always_comb begin
    in_wait_ack = (state_q == WAIT_ACK1) || (state_q == WAIT_ACK2);
    second_byte = (state_q == WAIT_SENT2) || (state_q == WAIT_ACK2);
    ack_byte    = bus.received_data_en && (bus.received_data == KB_ACK);
    resend_byte = bus.received_data_en && (bus.received_data == KB_RESEND);
    rx_consumed = in_wait_ack && (ack_byte || resend_byte);
    rx_fwd      = bus.received_data_en && !rx_consumed;
    rx_en_d     = rx_fwd;
    rx_data_d   = rx_fwd ? bus.received_data : rx_data_q;
  end

`ifdef LOCK_TRACK_EN
  localparam logic [7:0] PFX_BREAK = 8'hF0;
  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_NUM    = 8'h77;
  localparam logic [7:0] SC_SCROLL = 8'h7E;

  logic [2:0] lock_q, lock_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic       trk_req;

  always_comb begin
    lock_d  = lock_q;
    brk_d   = brk_q;
    ext_d   = ext_q;
    trk_req = 1'b0;
    if (rx_fwd) begin
      if (bus.received_data == PFX_EXT) begin
        ext_d = 1'b1;
      end else if (bus.received_data == PFX_BREAK) begin
        brk_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!brk_q && !ext_q) begin
          case (bus.received_data)
            SC_CAPS:   begin lock_d[2] = ~lock_q[2]; trk_req = 1'b1; end
            SC_NUM:    begin lock_d[1] = ~lock_q[1]; trk_req = 1'b1; end
            SC_SCROLL: begin lock_d[0] = ~lock_q[0]; trk_req = 1'b1; end
            default:   ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      lock_q <= '0;
      brk_q  <= 1'b0;
      ext_q  <= 1'b0;
    end else begin
      lock_q <= lock_d;
      brk_q  <= brk_d;
      ext_q  <= ext_d;
    end
  end

  // An external request in the same cycle overrides the tracked value.
  assign req     = bus.led_req || trk_req;
  assign req_val = bus.led_req ? bus.led_val : lock_d;
`else
  assign req     = bus.led_req;
  assign req_val = bus.led_val;
`endif

  // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    arg_d          = arg_q;
    pend_d         = pend_q;
    pend_val_d     = pend_val_q;
    retry_d        = retry_q;
    tmo_d          = tmo_q;
    leds_applied_d = leds_applied_q;
    the_command_d  = the_command_q;
    send_command_d = 1'b0;
    done_d         = 1'b0;
    fail_d         = 1'b0;
    attempt_failed = 1'b0;
    retry_next     = {1'b0, retry_q} + (RTY_W + 1)'(1);

    if ((state_q != IDLE) && req) begin
      pend_d     = 1'b1;
      pend_val_d = req_val;
    end

    case (state_q)
      IDLE: begin
        if (req) begin
          arg_d   = req_val;
          pend_d  = 1'b0;
          state_d = TX_CMD;
        end else if (pend_q) begin
          arg_d   = pend_val_q;
          pend_d  = 1'b0;
          state_d = TX_CMD;
        end
      end
      TX_CMD: state_d = WAIT_SENT1;
      TX_ARG: state_d = WAIT_SENT2;
      WAIT_SENT1, WAIT_SENT2: begin
        if (bus.command_was_sent) begin
          tmo_d   = '0;
          state_d = second_byte ? WAIT_ACK2 : WAIT_ACK1;
        end else if (bus.error_communication_timed_out) begin
          attempt_failed = 1'b1;
        end
      end
      WAIT_ACK1, WAIT_ACK2: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (ack_byte) begin
          retry_d = '0;
          if (second_byte) begin
            leds_applied_d = arg_q;
            done_d         = 1'b1;
            state_d        = IDLE;
          end else begin
            state_d = TX_ARG;
          end
        end else if (resend_byte || (tmo_q == TMO_LAST)) begin
          attempt_failed = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (attempt_failed) begin
      if (retry_next < RTY_LIMIT) begin
        retry_d = retry_next[RTY_W-1:0];
        state_d = second_byte ? TX_ARG : TX_CMD;
      end else begin
        fail_d  = 1'b1;
        retry_d = '0;
        state_d = IDLE;
      end
    end

    // The byte and its strobe are registered on entry, so both are valid during the TX state.
    if (state_d == TX_CMD) begin
      send_command_d = 1'b1;
      the_command_d  = CMD_SET_LEDS;
    end else if (state_d == TX_ARG) begin
      send_command_d = 1'b1;
      the_command_d  = {5'b0, arg_q};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q        <= IDLE;
      arg_q          <= '0;
      pend_q         <= 1'b0;
      pend_val_q     <= '0;
      retry_q        <= '0;
      tmo_q          <= '0;
      leds_applied_q <= '0;
      the_command_q  <= '0;
      send_command_q <= 1'b0;
      done_q         <= 1'b0;
      fail_q         <= 1'b0;
      rx_data_q      <= '0;
      rx_en_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      arg_q          <= arg_d;
      pend_q         <= pend_d;
      pend_val_q     <= pend_val_d;
      retry_q        <= retry_d;
      tmo_q          <= tmo_d;
      leds_applied_q <= leds_applied_d;
      the_command_q  <= the_command_d;
      send_command_q <= send_command_d;
      done_q         <= done_d;
      fail_q         <= fail_d;
      rx_data_q      <= rx_data_d;
      rx_en_q        <= rx_en_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.fail         = fail_q;
  assign bus.leds_applied = leds_applied_q;
  assign bus.the_command  = the_command_q;
  assign bus.send_command = send_command_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_en        = rx_en_q;

endmodule

// File: tb/tb_ps2_led_sequencer.sv
// Self-checking bench for ps2_led_sequencer: directed scenarios plus randomized keyboard
// replies, checked against a transaction-level model of the Set-LEDs retry rules.
module tb_ps2_led_sequencer;
  localparam int ACK_TMO = 100;
  localparam int MAX_RTY = 3;

  typedef enum int {R_ACK, R_RESEND, R_TMO, R_TXERR} reply_t;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  ps2_led_sequencer_if bus ();

  ps2_led_sequencer #(
    .ACK_TIMEOUT(ACK_TMO),
    .MAX_RETRY  (MAX_RTY)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Monitor: every send strobe, done and fail pulse, sampled mid-cycle.
  logic [7:0] sent_q[$];
  int         sent_cyc[$];
  int         done_cnt = 0;
  int         fail_cnt = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (bus.send_command) begin
        sent_q.push_back(bus.the_command);
        sent_cyc.push_back(cyc);
      end
      if (bus.done) done_cnt++;
      if (bus.fail) fail_cnt++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus.received_data    = b;
    bus.received_data_en = 1'b1;
    tick();
    bus.received_data_en = 1'b0;
  endtask

  task automatic request(input logic [2:0] v);
    bus.led_req = 1'b1;
    bus.led_val = v;
    tick();
    bus.led_req = 1'b0;
    check("busy_start", bus.busy, 1);
  endtask

  // Reference model: one reply per attempt; ACK advances to the next byte and resets the
  // attempt count, anything else is a failed attempt; MAX_RTY failures abandon the transaction.
  reply_t     script[$];
  logic [7:0] exp_sent[$];
  int         n_used;
  bit         exp_ok;
  logic [2:0] leds_model = 3'b000;

  function automatic void model(input logic [2:0] arg);
    int stage = 0;
    int tries = 0;
    exp_sent.delete();
    n_used = 0;
    exp_ok = 1'b0;
    for (int i = 0; i < script.size(); i++) begin
      exp_sent.push_back((stage == 0) ? 8'hED : {5'b0, arg});
      n_used++;
      if (script[i] == R_ACK) begin
        stage++;
        tries = 0;
        if (stage == 2) begin
          exp_ok = 1'b1;
          break;
        end
      end else begin
        tries++;
        if (tries == MAX_RTY) break;
      end
    end
  endfunction

  function automatic logic [7:0] pick_noise();
    logic [7:0] b;
    do b = 8'($urandom_range(1, 8'hDF));
    while (b == 8'h58 || b == 8'h77 || b == 8'h7E);
    return b;
  endfunction

  int sent_seen = 0;

  task automatic wait_send(output bit got);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (sent_q.size() > sent_seen) begin
        got = 1'b1;
        sent_seen++;
        break;
      end
      tick();
    end
    if (!got) check("send_seen", 0, 1);
  endtask

  task automatic wait_end(input int events);
    for (int i = 0; i < 400 && (done_cnt + fail_cnt) < events; i++) tick();
  endtask

  // Plays controller + keyboard for the first n_used replies of the script.
  task automatic play(input bit rand_dly, input logic [7:0] noise0);
    bit         got;
    bit         last;
    logic [7:0] noise;
    for (int i = 0; i < n_used; i++) begin
      last = (i == n_used - 1);
      wait_send(got);
      if (!got) return;
      if (rand_dly) tick($urandom_range(0, 3));
      if (script[i] == R_TXERR) begin
        bus.error_communication_timed_out = 1'b1;
        tick();
        bus.error_communication_timed_out = 1'b0;
        check("fail_after_txerr", bus.fail, last && !exp_ok);
        continue;
      end
      bus.command_was_sent = 1'b1;
      tick();
      bus.command_was_sent = 1'b0;
      if (script[i] == R_TMO) continue;
      if (rand_dly) tick($urandom_range(0, 20));
      noise = 8'h00;
      if (i == 0 && noise0 != 8'h00) noise = noise0;
      else if (rand_dly && $urandom_range(0, 2) == 0) noise = pick_noise();
      if (noise != 8'h00) begin
        rx_byte(noise);
        check("rx_pass_in_ack", {23'b0, bus.rx_en, bus.rx_data}, {23'b0, 1'b1, noise});
        if (rand_dly) tick($urandom_range(0, 3));
      end
      rx_byte((script[i] == R_ACK) ? 8'hFA : 8'hFE);
      check("ack_suppressed", bus.rx_en, 0);
      check("done_pulse", bus.done, last && exp_ok);
      check("fail_pulse", bus.fail, last && !exp_ok && script[i] != R_ACK);
    end
  endtask

  task automatic check_sent(input int s0);
    check("sent_count", sent_q.size() - s0, exp_sent.size());
    for (int i = 0; i < exp_sent.size() && s0 + i < sent_q.size(); i++)
      check("sent_byte", sent_q[s0 + i], exp_sent[i]);
  endtask

  task automatic run_txn(input logic [2:0] val, input bit rand_dly, input logic [7:0] noise0);
    int s0 = sent_q.size();
    int d0 = done_cnt;
    int f0 = fail_cnt;
    model(val);
    request(val);
    play(rand_dly, noise0);
    wait_end(d0 + f0 + 1);
    check_sent(s0);
    check("done_count", done_cnt - d0, exp_ok);
    check("fail_count", fail_cnt - f0, !exp_ok);
    if (exp_ok) leds_model = val;
    check("leds_applied", bus.leds_applied, leds_model);
    tick();
    check("busy_after", bus.busy, 0);
  endtask

  initial begin
    int s0;
    int d0;
    int f0;
    bit got;

    bus.led_req                       = 1'b0;
    bus.led_val                       = 3'b000;
    bus.command_was_sent              = 1'b0;
    bus.error_communication_timed_out = 1'b0;
    bus.received_data                 = 8'h00;
    bus.received_data_en              = 1'b0;

    tick(3);
    reset = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_done_fail", {bus.done, bus.fail}, 0);
    check("rst_leds", bus.leds_applied, 0);
    check("rst_cmd", {bus.send_command, bus.the_command}, 0);
    check("rst_rx", {bus.rx_en, bus.rx_data}, 0);
    tick(2);

    // Normal set
    script.delete();
    repeat (8) script.push_back(R_ACK);
    run_txn(3'b101, 1'b0, 8'h00);

    // Resend on the command byte
    script.delete();
    script.push_back(R_RESEND);
    repeat (7) script.push_back(R_ACK);
    run_txn(3'b110, 1'b0, 8'h00);

    // Timeout exhaust: three ED transmissions, each ACK_TMO plus TX and WAIT_SENT cycles apart
    script.delete();
    repeat (8) script.push_back(R_TMO);
    s0 = sent_q.size();
    run_txn(3'b011, 1'b0, 8'h00);
    if (sent_q.size() >= s0 + 3) begin
      check("tmo_gap1", sent_cyc[s0 + 1] - sent_cyc[s0], ACK_TMO + 2);
      check("tmo_gap2", sent_cyc[s0 + 2] - sent_cyc[s0 + 1], ACK_TMO + 2);
    end

    // Passthrough of a scan code during WAIT_ACK1
    script.delete();
    repeat (8) script.push_back(R_ACK);
    run_txn(3'b011, 1'b0, 8'h1C);

    // Pending requests while busy: last value wins, serviced right after completion
    s0 = sent_q.size();
    d0 = done_cnt;
    script.delete();
    repeat (8) script.push_back(R_ACK);
    model(3'b001);
    request(3'b001);
    bus.led_req = 1'b1;
    bus.led_val = 3'b010;
    tick();
    bus.led_val = 3'b100;
    tick();
    bus.led_req = 1'b0;
    play(1'b0, 8'h00);
    wait_end(d0 + fail_cnt + 1);
    check("pend_leds1", bus.leds_applied, 3'b001);
    model(3'b100);
    play(1'b0, 8'h00);
    wait_end(d0 + fail_cnt + 2);
    exp_sent.delete();
    exp_sent.push_back(8'hED);
    exp_sent.push_back(8'h01);
    exp_sent.push_back(8'hED);
    exp_sent.push_back(8'h04);
    check_sent(s0);
    leds_model = 3'b100;
    check("pend_leds2", bus.leds_applied, leds_model);
    check("pend_done", done_cnt - d0, 2);
    tick();
    check("pend_idle", bus.busy, 0);

    // Outside WAIT_ACK even FA/FE are forwarded
    rx_byte(8'hFA);
    check("idle_fa_fwd", {23'b0, bus.rx_en, bus.rx_data}, {23'b0, 1'b1, 8'hFA});
    rx_byte(8'hFE);
    check("idle_fe_fwd", {23'b0, bus.rx_en, bus.rx_data}, {23'b0, 1'b1, 8'hFE});
    tick();
    check("rx_en_drop", bus.rx_en, 0);

`ifndef LOCK_TRACK_EN
    // Without lock tracking a caps make code is just data
    s0 = sent_q.size();
    rx_byte(8'h58);
    check("caps_fwd", {23'b0, bus.rx_en, bus.rx_data}, {23'b0, 1'b1, 8'h58});
    tick(5);
    check("caps_no_txn", {bus.busy, 31'(sent_q.size() - s0)}, 0);
`endif

    // Randomized replies, delays and interleaved scan codes
    for (int t = 0; t < 16; t++) begin
      int r;
      script.delete();
      for (int k = 0; k < 8; k++) begin
        r = $urandom_range(0, 99);
        script.push_back((r < 55) ? R_ACK : (r < 70) ? R_RESEND : (r < 85) ? R_TMO : R_TXERR);
      end
      run_txn(3'($urandom_range(0, 7)), 1'b1, 8'h00);
    end

    // Reset mid-transaction with a request pending: abort silently, nothing resumes
    request(3'b110);
    wait_send(got);
    bus.led_req = 1'b1;
    bus.led_val = 3'b011;
    tick();
    bus.led_req = 1'b0;
    d0 = done_cnt;
    f0 = fail_cnt;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    leds_model = 3'b000;
    check("midrst_busy", bus.busy, 0);
    check("midrst_leds", bus.leds_applied, leds_model);
    s0 = sent_q.size();
    tick(20);
    check("midrst_no_send", sent_q.size() - s0, 0);
    check("midrst_no_pulse", (done_cnt - d0) + (fail_cnt - f0), 0);
    check("midrst_idle", bus.busy, 0);
    sent_seen = sent_q.size();

`ifdef LOCK_TRACK_EN
    // Caps make toggles on, break code is ignored, next make toggles off
    s0 = sent_q.size();
    d0 = done_cnt;
    script.delete();
    repeat (8) script.push_back(R_ACK);
    model(3'b100);
    rx_byte(8'h58);
    check("lock_busy", bus.busy, 1);
    play(1'b0, 8'h00);
    wait_end(d0 + fail_cnt + 1);
    check_sent(s0);
    leds_model = 3'b100;
    check("lock_leds_on", bus.leds_applied, leds_model);
    s0 = sent_q.size();
    rx_byte(8'hF0);
    rx_byte(8'h58);
    tick(5);
    check("lock_break_ignored", {bus.busy, 31'(sent_q.size() - s0)}, 0);
    model(3'b000);
    rx_byte(8'h58);
    play(1'b0, 8'h00);
    wait_end(d0 + fail_cnt + 2);
    check_sent(s0);
    leds_model = 3'b000;
    check("lock_leds_off", bus.leds_applied, leds_model);
`endif

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
